bht_ctrl: RTL

Controller and owner of an indexed table of 2-bit saturating branch counters, using the SNT/WNT/WT/ST encoding 00/01/10/11. The table has a single access port, shared between the fetch-stage lookup requester and the execute-stage resolved-branch update requester. The block queues updates, arbitrates the port each cycle, and runs a table-clear sweep after reset or on flush. It sits between the fetch PC generator and the EX branch resolution logic.

---
 rtl/bht_pkg.sv | 32 +++
 rtl/bht_ctrl_upd_fifo.sv | 40 ++++
 rtl/bht_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table controller.
// Holds counter encodings, FSM state, update-queue entry and saturation helper.
package bht_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Widest index an entry can carry.
  localparam int IDX_MAX_W = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_e;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 taken;
  } upd_ent_t;

  function automatic logic [1:0] sat_update(
    input logic [1:0] cnt,
    input logic       taken
  );
    if (taken)
      return (cnt == ST) ? ST : cnt + 2'd1;
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_ctrl_upd_fifo.sv
// Update queue: UQ_DEPTH-entry FIFO, entry 0 is the oldest.
// Ports: clr (discard), enq/din, deq, ents (all entries), cnt (occupancy).
module bht_ctrl_upd_fifo
  import bht_pkg::*;
#(
  parameter int UQ_DEPTH = 2,
  parameter int CNT_W    = $clog2(UQ_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       enq,
  input  upd_ent_t                   din,
  input  logic                       deq,
  output upd_ent_t [UQ_DEPTH-1:0]    ents,
  output logic     [CNT_W-1:0]       cnt
);

  logic [CNT_W-1:0] wr_ptr;

  // With a dequeue the new entry lands one slot lower after the shift.
  assign wr_ptr = cnt - CNT_W'(deq);

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge clk) begin
    if (deq) begin
      for (int i = 0; i < UQ_DEPTH - 1; i++)
        ents[i] <= ents[i+1];
    end
    if (enq)
      ents[wr_ptr] <= din;
  end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit counters, single port, update queue.
// Ports: lk_* fetch lookup, upd_* EX update, flush_req, init_busy. Macro BHT_FWD_EN.
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 6,
  parameter int UQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_ready,
  output logic            lk_pred_valid,
  output logic            lk_pred,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            upd_ready,
  input  logic            flush_req,
  output logic            init_busy
);

  localparam int N     = 1 << IDX_W;
  localparam int CNT_W = $clog2(UQ_DEPTH + 1);

  bht_state_e              state;
  logic [IDX_W-1:0]        sweep;
  logic [1:0]              tbl [N];

  upd_ent_t [UQ_DEPTH-1:0] q_ents;
  logic [CNT_W-1:0]        q_cnt;
  upd_ent_t                q_din;
  upd_ent_t                head;

  logic             run;
  logic             q_full;
  logic             q_empty;
  logic             lk_fire;
  logic             enq;
  logic             deq;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] head_idx;
  logic [1:0]       rd_cnt;
  logic             unused_ok;

  assign run      = (state == RUN);
  assign q_full   = (q_cnt == CNT_W'(UQ_DEPTH));
  assign q_empty  = (q_cnt == '0);
  assign lk_idx   = lk_pc[IDX_W+1:2];
  assign head     = q_ents[0];
  assign head_idx = head.idx[IDX_W-1:0];

  assign init_busy = ~run;
  assign lk_ready  = run & ~q_full;
  assign upd_ready = ~q_full & ~flush_req;

  // Full queue steals the port; otherwise lookups win over drains.
  assign lk_fire = lk_valid & lk_ready;
  assign enq     = upd_valid & upd_ready;
  assign deq     = run & ~q_empty & (q_full | ~lk_valid);

  assign q_din.idx   = IDX_MAX_W'(upd_pc[IDX_W+1:2]);
  assign q_din.taken = upd_taken;

  assign unused_ok = ^{lk_pc[1:0], lk_pc[PC_W-1:IDX_W+2],
                       upd_pc[1:0], upd_pc[PC_W-1:IDX_W+2],
                       q_ents};

  bht_ctrl_upd_fifo #(
    .UQ_DEPTH (UQ_DEPTH),
    .CNT_W    (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_req),
    .enq   (enq),
    .din   (q_din),
    .deq   (deq),
    .ents  (q_ents),
    .cnt   (q_cnt)
  );

  always_comb begin
    rd_cnt = tbl[lk_idx];
`ifdef BHT_FWD_EN
    // Fold pending updates for this index in queue order.
    for (int i = 0; i < UQ_DEPTH; i++) begin
      if ((CNT_W'(i) < q_cnt) &&
          (q_ents[i].idx[IDX_W-1:0] == lk_idx))
        rd_cnt = sat_update(rd_cnt, q_ents[i].taken);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)
        tbl[sweep] <= SNT;
      else if (deq)
        tbl[head_idx] <= sat_update(tbl[head_idx], head.taken);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (flush_req) begin
            sweep <= '0;
          end else if (sweep == '1) begin
            state <= RUN;
            sweep <= '0;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        RUN: begin
          if (flush_req) begin
            state <= INIT;
            sweep <= '0;
          end
        end
        default: begin
          state <= INIT;
          sweep <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_pred_valid <= 1'b0;
      lk_pred       <= 1'b0;
    end else begin
      lk_pred_valid <= lk_fire;
      if (lk_fire)
        lk_pred <= rd_cnt[1];
    end
  end

endmodule
